out_tx_buffer: RTL and testbench

Output-side peripheral for the multi-cycle core. It accepts `out_req`/`out_data` words from the core's execute stage and asserts `out_busy` to stall the core when it cannot accept more. Accepted words are queued in a FIFO and shifted out on an 8N1 UART line, low byte first. It sits between the core's output port and the board's UART TX pin.

---
 rtl/out_tx_pkg.sv | 14 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/out_tx_buffer.sv | 145 ++++++++++++++
 tb/tb_out_tx_buffer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_tx_pkg.sv
// out_tx_pkg: shared state type and UART framing constants for the output buffer.
package out_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered occupancy count and full/empty flags.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   // Flags come straight from the registered count, so out_busy has no input path.
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointer/count next state; pointers wrap naturally, push+pop leaves count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
      else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents after reset are irrelevant, so it is not reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/out_tx_buffer.sv
// out_tx_buffer: queues core output words and shifts them out as 8N1 UART frames, low byte first.
module out_tx_buffer
   import out_tx_pkg::*;
#(
   parameter int unsigned REG_W       = 32,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned OUT_BYTES   = 1,
   parameter int unsigned CLK_PER_BIT = 868
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             out_req,
   input  logic [REG_W-1:0] out_data,
   output logic             out_busy,
   output logic             txd,
   output logic             tx_active
);

   localparam int unsigned       WORD_W      = UART_DATA_BITS * OUT_BYTES;
   localparam int unsigned       BAUD_W      = $clog2(CLK_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_PER_BIT - 1);
   localparam logic [2:0]        LAST_BIT    = 3'(UART_DATA_BITS - 1);
   localparam logic [1:0]        LAST_BYTE   = 2'(OUT_BYTES - 1);

   tx_state_t         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [WORD_W-1:0] word_q, word_d, word_shifted;
   logic [7:0]        tx_byte_q, tx_byte_d;
   logic              fifo_pop, fifo_full, fifo_empty;
   logic [WORD_W-1:0] fifo_rdata;
   logic              baud_done;
   logic              unused_data;

   // Only the low OUT_BYTES bytes of a word are ever transmitted.
   assign unused_data  = ^out_data;
   assign baud_done    = (baud_q == '0);
   assign word_shifted = word_q >> UART_DATA_BITS;

   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (out_req),
      .wdata_i (out_data[WORD_W-1:0]),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // State, baud counter, bit/byte sequencer and shift registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         tx_byte_q  <= '0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         tx_byte_q  <= tx_byte_d;
      end
   end

   // Next-state: frame sequencing; the baud counter reloads on every state or bit change.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      tx_byte_d  = tx_byte_q;
      fifo_pop   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && byte_idx_q == '0) begin
               fifo_pop  = 1'b1;
               word_d    = fifo_rdata;
               tx_byte_d = fifo_rdata[7:0];
               baud_d    = BAUD_RELOAD;
               state_d   = START;
            end
         end
         START: begin
            if (baud_done) begin
               bit_d   = '0;
               baud_d  = BAUD_RELOAD;
               state_d = DATA;
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_d    = BAUD_RELOAD;
               tx_byte_d = {1'b0, tx_byte_q[7:1]};
               if (bit_q == LAST_BIT) state_d = STOP;
               else                   bit_d   = bit_q + 3'd1;
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_d = BAUD_RELOAD;
               // byte_idx only counts up from 0, so != is the same test as < here.
               if (byte_idx_q != LAST_BYTE) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  word_d     = word_shifted;
                  tx_byte_d  = word_shifted[7:0];
                  state_d    = START;
               end else begin
                  byte_idx_d = '0;
                  state_d    = IDLE;
               end
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: line level from state, activity and stall flags.
   always_comb begin
      txd = 1'b1;
      case (state_q)
         START:   txd = 1'b0;
         DATA:    txd = tx_byte_q[0];
         default: txd = 1'b1;
      endcase
      tx_active = !fifo_empty || (state_q != IDLE);
      out_busy  = fifo_full;
   end

endmodule

// File: tb/tb_out_tx_buffer.sv
// tb_out_tx_buffer: two buffers (1-byte and 4-byte words) driven by shared stimulus and checked
// cycle by cycle against a frame-timing reference model, plus directed corner sequences.
module tb_out_tx_buffer;

   localparam int unsigned CPB    = 4;
   localparam int unsigned DEPTH  = 4;
   localparam int          HIST_N = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        out_req;
   logic [31:0] out_data;
   logic [1:0]  busy, txd, act;

   out_tx_buffer #(.REG_W(32), .DEPTH(DEPTH), .OUT_BYTES(1), .CLK_PER_BIT(CPB)) dut_b1 (
      .clk(clk), .rst(rst), .out_req(out_req), .out_data(out_data),
      .out_busy(busy[0]), .txd(txd[0]), .tx_active(act[0]));

   out_tx_buffer #(.REG_W(32), .DEPTH(DEPTH), .OUT_BYTES(4), .CLK_PER_BIT(CPB)) dut_b4 (
      .clk(clk), .rst(rst), .out_req(out_req), .out_data(out_data),
      .out_busy(busy[1]), .txd(txd[1]), .tx_active(act[1]));

   always #5 clk = ~clk;

   int unsigned tests = 0;
   int unsigned fails = 0;
   longint      cyc   = 0;

   // Reference model: queued words, plus the start/end cycle of the word being sent.
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] m_word [2];
   longint      m_fs [2];
   longint      m_fe [2];

   logic   hist [2][HIST_N];
   bit     rec_on = 1'b0;
   longint rec_base = 0;

   typedef struct {
      logic        req;
      logic [31:0] data;
      logic        txd;
      logic        act;
      logic        busy;
   } vec_t;
   vec_t tbl [44];

   function automatic int ob(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   // Line level: start bit 0, data LSB first, stop 1, each held CPB cycles; bytes contiguous.
   function automatic logic exp_txd(input int i);
      longint      off;
      int          bytei, b;
      logic [31:0] w;
      if (cyc < m_fs[i] || cyc >= m_fe[i]) return 1'b1;
      off   = (cyc - m_fs[i]) / longint'(CPB);
      bytei = int'(off / 10);
      b     = int'(off % 10);
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      w = m_word[i] >> (8 * bytei);
      return w[b - 1];
   endfunction

   function automatic logic exp_act(input int i);
      return (qsize(i) != 0) || (cyc < m_fe[i]);
   endfunction

   task automatic chk_bit(input string name, input logic got, input logic exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, got, exp);
      end
   endtask

   task automatic chk_val(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
      end
   endtask

   task automatic check_model();
      for (int i = 0; i < 2; i++) begin
         chk_bit($sformatf("m%0d_txd", i), txd[i], exp_txd(i));
         chk_bit($sformatf("m%0d_active", i), act[i], exp_act(i));
         chk_bit($sformatf("m%0d_busy", i), busy[i], qsize(i) == int'(DEPTH));
      end
   endtask

   // Advance the model across one clock edge using the inputs sampled at that edge.
   task automatic model_update(input logic r, input logic rq, input logic [31:0] d);
      for (int i = 0; i < 2; i++) begin
         bit pop, push;
         if (r) begin
            if (i == 0) q0.delete(); else q1.delete();
            m_fs[i] = 0;
            m_fe[i] = 0;
         end else begin
            pop  = (qsize(i) > 0) && (cyc >= m_fe[i]);
            push = rq && (qsize(i) < int'(DEPTH));
            if (pop) begin
               if (i == 0) m_word[i] = q0.pop_front();
               else        m_word[i] = q1.pop_front();
               m_fs[i] = cyc + 1;
               m_fe[i] = cyc + 1 + longint'(10 * ob(i) * int'(CPB));
            end
            if (push) begin
               if (i == 0) q0.push_back(d);
               else        q1.push_back(d);
            end
         end
      end
   endtask

   task automatic cycle_io(input logic r, input logic rq, input logic [31:0] d);
      int idx;
      rst      = r;
      out_req  = rq;
      out_data = d;
      @(negedge clk);
      check_model();
      idx = int'(cyc - rec_base);
      if (rec_on && idx >= 0 && idx < HIST_N) begin
         hist[0][idx] = txd[0];
         hist[1][idx] = txd[1];
      end
   endtask

   task automatic advance();
      @(posedge clk);
      model_update(rst, out_req, out_data);
      cyc++;
      #1;
   endtask

   task automatic step(input logic r, input logic rq, input logic [31:0] d);
      cycle_io(r, rq, d);
      advance();
   endtask

   task automatic wait_idle(input int maxc);
      for (int n = 0; n < maxc; n++) begin
         cycle_io(1'b0, 1'b0, '0);
         if (act == 2'b00) begin
            advance();
            return;
         end
         advance();
      end
      tests++;
      fails++;
      $display("FAIL idle_timeout at cycle %0d: got active=%b, expected 00", cyc, act);
   endtask

   // Decode one byte from recorded line history; s is the first cycle of its start bit.
   function automatic logic [7:0] get_byte(input int i, input int s);
      logic [7:0] v;
      for (int b = 0; b < 8; b++) v[b] = hist[i][s + (b + 1) * int'(CPB) + int'(CPB) / 2];
      return v;
   endfunction

   initial begin
      logic [9:0] fb;
      logic [7:0] be_bytes [4];
      int         f;

      // 0x41 frame: start, 1,0,0,0,0,0,1,0, stop (bit position p is fb[p]).
      fb = 10'b1010000010;
      tbl[0] = '{1'b1, 32'h0000_0041, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0};
      for (int k = 2; k < 42; k++) tbl[k] = '{1'b0, 32'h0, fb[(k - 2) / 4], 1'b1, 1'b0};
      tbl[42] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
      tbl[43] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
      be_bytes[0] = 8'hEF; be_bytes[1] = 8'hBE; be_bytes[2] = 8'hAD; be_bytes[3] = 8'hDE;

      rst = 1'b1; out_req = 1'b0; out_data = '0;
      advance();
      advance();

      // Reset state, with a request held alongside reset to show reset wins.
      cycle_io(1'b1, 1'b1, 32'h77);
      for (int i = 0; i < 2; i++) begin
         chk_bit($sformatf("rst%0d_txd", i), txd[i], 1'b1);
         chk_bit($sformatf("rst%0d_active", i), act[i], 1'b0);
         chk_bit($sformatf("rst%0d_busy", i), busy[i], 1'b0);
      end
      advance();
      cycle_io(1'b0, 1'b0, '0);
      chk_bit("rst_req_dropped", act[0], 1'b0);
      advance();

      // Table: single 0x41 word on the 1-byte buffer; row index = cycles since the request.
      for (int k = 0; k < 44; k++) begin
         cycle_io(1'b0, tbl[k].req, tbl[k].data);
         chk_bit($sformatf("tbl%0d_txd", k), txd[0], tbl[k].txd);
         chk_bit($sformatf("tbl%0d_active", k), act[0], tbl[k].act);
         chk_bit($sformatf("tbl%0d_busy", k), busy[0], tbl[k].busy);
         advance();
      end
      wait_idle(400);

      // 0xDEADBEEF on the 4-byte buffer: four frames, no gap between them.
      rec_base = cyc; rec_on = 1'b1;
      step(1'b0, 1'b1, 32'hDEAD_BEEF);
      for (int k = 0; k < 170; k++) step(1'b0, 1'b0, '0);
      rec_on = 1'b0;
      f = -1;
      for (int j = 0; j < 200; j++) if (f < 0 && hist[1][j] == 1'b0) f = j;
      chk_val("b4_first_fall", f, 2);
      for (int k = 0; k < 4; k++) begin
         chk_val($sformatf("b4_byte%0d", k), int'(get_byte(1, 2 + 40 * k)), int'(be_bytes[k]));
         chk_bit($sformatf("b4_start%0d", k), hist[1][2 + 40 * k + 2], 1'b0);
         chk_bit($sformatf("b4_stop%0d", k), hist[1][2 + 40 * k + 38], 1'b1);
      end
      wait_idle(400);

      // Six back-to-back pushes into DEPTH=4, then request held until the first pop cycle.
      rec_base = cyc; rec_on = 1'b1;
      for (int r = 0; r < 46; r++) begin
         cycle_io(1'b0, r < 43, (r < 6) ? 32'h10 + r : 32'hEE);
         if (r == 4)  chk_bit("full_r4", busy[0], 1'b0);
         if (r == 5)  chk_bit("full_r5", busy[0], 1'b1);
         if (r == 42) chk_bit("full_popcycle", busy[0], 1'b1);
         if (r == 43) chk_bit("full_after_pop", busy[0], 1'b0);
         if (r == 45) chk_bit("full_stays_low", busy[0], 1'b0);
         advance();
      end
      wait_idle(1500);
      rec_on = 1'b0;
      for (int k = 0; k < 5; k++)
         chk_val($sformatf("full_byte%0d", k), int'(get_byte(0, 2 + 41 * k)), 32'h10 + k);
      chk_bit("full_no_sixth", hist[0][2 + 41 * 5 + 2], 1'b1);

      // Reset in DATA with three words queued; then a clean 0x55.
      for (int r = 0; r < 4; r++) step(1'b0, 1'b1, 32'hA0 + r);
      for (int r = 0; r < 9; r++) step(1'b0, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      cycle_io(1'b0, 1'b0, '0);
      for (int i = 0; i < 2; i++) begin
         chk_bit($sformatf("midrst%0d_txd", i), txd[i], 1'b1);
         chk_bit($sformatf("midrst%0d_active", i), act[i], 1'b0);
         chk_bit($sformatf("midrst%0d_busy", i), busy[i], 1'b0);
      end
      advance();
      rec_base = cyc; rec_on = 1'b1;
      step(1'b0, 1'b1, 32'h55);
      wait_idle(400);
      rec_on = 1'b0;
      chk_val("midrst_byte", int'(get_byte(0, 2)), 32'h55);
      chk_bit("midrst_start", hist[0][4], 1'b0);

      // Pointer wrap: 3*DEPTH+1 isolated pushes.
      for (int n = 0; n < 3 * int'(DEPTH) + 1; n++) begin
         step(1'b0, 1'b1, $urandom);
         wait_idle(250);
      end

      // Random traffic with occasional reset.
      for (int n = 0; n < 3000; n++)
         step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 30, $urandom);
      wait_idle(2000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
      $fatal(1);
   end

endmodule
